perceptron_neuron: RTL and testbench
====================================

Name: perceptron_neuron

Overview:
Single-neuron compute stage that sits directly downstream of the weight bank in the perceptron design.
- Consumes a serial stream of (input, weight) pairs plus a bias.
- Produces a signed accumulator and a binary classification.
- In training mode, applies the perceptron learning rule and streams the corrected weights back to the bank for write-back.

Parameters:
N_INPUTS, 4, maximum elements per evaluation; elements are indexed 0..N_INPUTS-1
DW, 8, signed width of x, w and bias (two's complement)
AW, 20, signed accumulator width
LR_SHIFT, 2, learning rate; the update step is x arithmetic-shifted right by LR_SHIFT

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins an evaluation; honoured only in IDLE
train  in  1  sampled at start; when 1, an update follows a misclassification
target  in  1  sampled at start; desired class (1 means +1, 0 means -1)
bias  in  DW  sampled at start; sign-extended into acc
in_valid  in  1  element beat valid
in_ready  out  1  element beat accepted when in_valid and in_ready are both 1
in_x  in  DW  signed input value
in_w  in  DW  signed weight value
in_last  in  1  marks the final element of an evaluation
busy  out  1  high in any state other than IDLE
acc  out  AW  signed accumulated sum; held until the next start
y  out  1  class output; 1 when acc >= 0
y_valid  out  1  one-cycle pulse when y and acc are final
len_err  out  1  one-cycle pulse, same cycle as y_valid, when in_last did not arrive on element N_INPUTS-1
w_valid  out  1  updated weight available
w_ready  in  1  downstream (bank) accepts the updated weight
w_idx  out  clog2(N_INPUTS)  element index of w_data
w_data  out  DW  updated signed weight

Behaviour:
- Reset (asynchronous, nRst=0): state IDLE. in_ready, busy, acc, y, y_valid, len_err, w_valid, w_idx and w_data are all 0. Element count and the x/w buffers are cleared. Reset mid-operation aborts immediately; no partial w output.
- States: IDLE, ACCUM, DECIDE, UPDATE.
- IDLE:
  - On start: latch train, target and bias; acc <= sext(bias); count <= 0; go to ACCUM next cycle.
  - start while busy is ignored.
- ACCUM:
  - in_ready=1.
  - Each accepted beat:
    - buffer x[count] and w[count];
    - acc <= sat_AW(acc + x*w), where the product is a full 2*DW signed value, sign-extended to AW;
    - count++.
  - The accepted beat with in_last=1, or the beat at count=N_INPUTS-1 (whichever comes first), ends the phase.
  - If the phase ends at count=N_INPUTS-1 without in_last, set the len_err flag.
  - in_ready drops the cycle after the terminating beat.
  - No timeout: the block waits indefinitely for in_valid.
- DECIDE (exactly one cycle, entered the cycle after the last beat):
  - y <= (acc >= 0); y_valid=1; len_err pulses if flagged.
  - err = +1 if target=1 and y=0; -1 if target=0 and y=1; else 0.
  - If train=1 and err != 0, go to UPDATE with w_idx=0; otherwise go to IDLE.
- UPDATE:
  - w_valid=1; w_data = sat_DW(w[i] + err*(x[i] >>> LR_SHIFT)), saturating to [-2^(DW-1), 2^(DW-1)-1].
  - w_data and w_idx are held stable while w_ready=0.
  - On w_valid and w_ready, advance i.
  - After index count-1 is accepted, w_valid drops and the block returns to IDLE.
  - Only the received elements are emitted (count may be below N_INPUTS).
- Latency: first beat accepted at start+1 at the earliest; y_valid occurs 1 cycle after the last accepted beat.
- acc saturates to signed AW limits; it never wraps.
- acc and y hold their values until the next start.

Test Plan:
- Inference, N=4, bias=0, x={10,20,-5,4}, w={3,-1,2,5}, train=0 -> y_valid one cycle after last beat, acc=20, y=1, w_valid never asserted.
- Same stream with w={-3,-1,2,5} -> acc=-40, y=0, len_err=0.
- Training, case 1 data, train=1, target=0 -> y=1, err=-1, w stream idx0..3 = {1,-6,4,4} on consecutive cycles with w_ready=1; then busy=0.
- Saturation: x={127,-128,0,0}, w={120,127,0,0}, bias=0, train=1, target=1 -> acc=-1016, y=0, w_data={127 (saturated),95,0,0}.
- Backpressure and short stream: in_last on element 1 with x={8,4}, w={-2,1}, train=1, target=1 -> acc=-12, y=0, len_err=0. Hold w_ready=0 for 3 cycles: w_idx=0, w_data=0 held stable. Then exactly 2 words: {0,2}.
- Robustness:
  - start pulsed during ACCUM is ignored.
  - 4 beats without in_last -> len_err pulses alongside y_valid.
  - nRst asserted mid-ACCUM -> all outputs 0 immediately, IDLE on release, next evaluation correct.

Source files
------------

// File: rtl/perceptron_neuron.sv
// Single perceptron neuron: serial multiply-accumulate, sign classify,
// and optional perceptron-rule weight update streamed back to the bank.
module perceptron_neuron #(
  parameter int N_INPUTS = 4,
  parameter int DW       = 8,
  parameter int AW       = 20,
  parameter int LR_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         nRst,
  input  logic                         start,
  input  logic                         train,
  input  logic                         target,
  input  logic signed [DW-1:0]         bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         in_x,
  input  logic signed [DW-1:0]         in_w,
  input  logic                         in_last,
  output logic                         busy,
  output logic signed [AW-1:0]         acc,
  output logic                         y,
  output logic                         y_valid,
  output logic                         len_err,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [$clog2(N_INPUTS)-1:0]  w_idx,
  output logic signed [DW-1:0]         w_data
);

  localparam int IW = $clog2(N_INPUTS);
  localparam int CW = IW + 1;

  localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [DW-1:0] WMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] WMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, UPDATE} state_t;

  state_t state_q, state_d;
  logic train_q, train_d;
  logic target_q, target_d;
  logic y_q, y_d;
  logic len_flag_q, len_flag_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] w_idx_q, w_idx_d;
  logic signed [DW-1:0] xb_q [N_INPUTS];
  logic signed [DW-1:0] xb_d [N_INPUTS];
  logic signed [DW-1:0] wb_q [N_INPUTS];
  logic signed [DW-1:0] wb_d [N_INPUTS];

  logic signed [2*DW-1:0] prod;
  logic signed [AW:0]     sum;
  logic signed [AW-1:0]   acc_sat;
  logic signed [DW-1:0]   step;
  logic signed [DW:0]     wsum;
  logic signed [DW-1:0]   w_sat;
  logic                   last_beat;
  logic                   last_word;

  always_comb begin
    prod = in_x * in_w;
    sum  = (AW+1)'(acc_q) + (AW+1)'(prod);
    if (sum[AW] != sum[AW-1]) acc_sat = sum[AW] ? AMIN : AMAX;
    else                      acc_sat = sum[AW-1:0];

    // err is -1 exactly when the neuron fired (y=1) but should not have
    step = xb_q[w_idx_q] >>> LR_SHIFT;
    if (y_q) wsum = (DW+1)'(wb_q[w_idx_q]) - (DW+1)'(step);
    else     wsum = (DW+1)'(wb_q[w_idx_q]) + (DW+1)'(step);
    if (wsum[DW] != wsum[DW-1]) w_sat = wsum[DW] ? WMIN : WMAX;
    else                        w_sat = wsum[DW-1:0];

    last_beat = in_last || (cnt_q == CW'(N_INPUTS - 1));
    last_word = ({1'b0, w_idx_q} == (cnt_q - CW'(1)));
  end

  always_comb begin
    state_d    = state_q;
    train_d    = train_q;
    target_d   = target_q;
    y_d        = y_q;
    len_flag_d = len_flag_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    w_idx_d    = w_idx_q;
    xb_d       = xb_q;
    wb_d       = wb_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          train_d    = train;
          target_d   = target;
          acc_d      = AW'(bias);
          cnt_d      = '0;
          len_flag_d = 1'b0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          xb_d[cnt_q[IW-1:0]] = in_x;
          wb_d[cnt_q[IW-1:0]] = in_w;
          acc_d = acc_sat;
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            y_d        = ~acc_sat[AW-1];
            len_flag_d = ~in_last;
            state_d    = DECIDE;
          end
        end
      end
      DECIDE: begin
        w_idx_d = '0;
        if (train_q && (y_q != target_q)) state_d = UPDATE;
        else                              state_d = IDLE;
      end
      UPDATE: begin
        if (w_ready) begin
          if (last_word) begin
            w_idx_d = '0;
            state_d = IDLE;
          end else begin
            w_idx_d = w_idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      train_q    <= 1'b0;
      target_q   <= 1'b0;
      y_q        <= 1'b0;
      len_flag_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      w_idx_q    <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        xb_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      train_q    <= train_d;
      target_q   <= target_d;
      y_q        <= y_d;
      len_flag_q <= len_flag_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      w_idx_q    <= w_idx_d;
      xb_q       <= xb_d;
      wb_q       <= wb_d;
    end
  end

  assign in_ready = (state_q == ACCUM);
  assign busy     = (state_q != IDLE);
  assign acc      = acc_q;
  assign y        = y_q;
  assign y_valid  = (state_q == DECIDE);
  assign len_err  = y_valid & len_flag_q;
  assign w_valid  = (state_q == UPDATE);
  assign w_idx    = w_idx_q;
  assign w_data   = w_valid ? w_sat : '0;

endmodule

// File: tb/tb_perceptron_neuron.sv
// Directed bench for perceptron_neuron: an integer reference model fills a
// scoreboard when an evaluation is driven; results are popped at y_valid.
module tb_perceptron_neuron;

  logic clk = 1'b0;
  logic nRst, start, train, target;
  logic in_valid, in_last, w_ready;
  logic signed [7:0] bias, in_x, in_w, w_data;
  logic in_ready, busy, y, y_valid, len_err, w_valid;
  logic signed [19:0] acc;
  logic [1:0] w_idx;

  int n_checks = 0;
  int n_fail = 0;

  typedef int arr4_t [4];
  typedef struct {
    int acc;
    int y;
    int len_err;
    bit upd;
    int n;
    int w [4];
  } exp_t;
  exp_t sbq [$];
  arr4_t xa, wa;

  perceptron_neuron #(.N_INPUTS(4), .DW(8), .AW(20), .LR_SHIFT(2)) dut (
    .clk(clk), .nRst(nRst), .start(start), .train(train),
    .target(target), .bias(bias), .in_valid(in_valid),
    .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .in_last(in_last), .busy(busy), .acc(acc), .y(y),
    .y_valid(y_valid), .len_err(len_err), .w_valid(w_valid),
    .w_ready(w_ready), .w_idx(w_idx), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".in_ready"}, in_ready, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".acc"}, acc, 0);
    chk({tag, ".y"}, y, 0);
    chk({tag, ".y_valid"}, y_valid, 0);
    chk({tag, ".len_err"}, len_err, 0);
    chk({tag, ".w_valid"}, w_valid, 0);
    chk({tag, ".w_idx"}, w_idx, 0);
    chk({tag, ".w_data"}, w_data, 0);
  endtask

  function automatic exp_t model(int b, bit tr, bit tg, int n, bit lst,
                                 arr4_t xs, arr4_t ws);
    exp_t e;
    int err, v;
    e.acc = b;
    for (int i = 0; i < n; i++) begin
      e.acc += xs[i] * ws[i];
      if (e.acc > 524287) e.acc = 524287;
      if (e.acc < -524288) e.acc = -524288;
    end
    e.y = (e.acc >= 0) ? 1 : 0;
    e.len_err = (n == 4 && !lst) ? 1 : 0;
    if (tg && e.y == 0) err = 1;
    else if (!tg && e.y == 1) err = -1;
    else err = 0;
    e.upd = tr && (err != 0);
    e.n = n;
    for (int i = 0; i < 4; i++) begin
      v = ws[i] + err * (xs[i] >>> 2);
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      e.w[i] = v;
    end
    return e;
  endfunction

  task automatic eval(string tag, int b, bit tr, bit tg, int n, bit lst,
                      int hold, bit mid_start);
    exp_t e;
    int k;
    @(negedge clk);
    sbq.push_back(model(b, tr, tg, n, lst, xa, wa));
    start = 1'b1;
    bias = 8'(b);
    train = tr;
    target = tg;
    @(negedge clk);
    start = 1'b0;
    bias = 8'sd77;
    train = ~tr;
    target = ~tg;
    chk({tag, ".busy"}, busy, 1);
    for (int i = 0; i < n; i++) begin
      chk({tag, ".in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_x = 8'(xa[i]);
      in_w = 8'(wa[i]);
      in_last = lst && (i == n - 1);
      if (mid_start && i == 1) begin
        start = 1'b1;
        bias = 8'sd100;
      end
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({tag, ".y_valid_latency"}, y_valid, 1);
    k = 0;
    while (!y_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    e = sbq.pop_front();
    chk({tag, ".acc"}, acc, e.acc);
    chk({tag, ".y"}, y, e.y);
    chk({tag, ".len_err"}, len_err, e.len_err);
    chk({tag, ".in_ready_drop"}, in_ready, 0);
    @(negedge clk);
    if (e.upd) begin
      repeat (hold) begin
        chk({tag, ".hold_valid"}, w_valid, 1);
        chk({tag, ".hold_idx"}, w_idx, 0);
        chk({tag, ".hold_data"}, w_data, e.w[0]);
        @(negedge clk);
      end
      for (int i = 0; i < e.n; i++) begin
        w_ready = 1'b1;
        chk({tag, ".w_valid"}, w_valid, 1);
        chk({tag, ".w_idx"}, w_idx, i);
        chk({tag, ".w_data"}, w_data, e.w[i]);
        @(negedge clk);
      end
      w_ready = 1'b0;
    end
    chk({tag, ".w_valid_end"}, w_valid, 0);
    chk({tag, ".y_valid_pulse"}, y_valid, 0);
    chk({tag, ".busy_end"}, busy, 0);
  endtask

  initial begin
    nRst = 1'b0;
    start = 1'b0;
    train = 1'b0;
    target = 1'b0;
    bias = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_x = '0;
    in_w = '0;
    w_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    nRst = 1'b1;

    xa = '{10, 20, -5, 4};
    wa = '{3, -1, 2, 5};
    eval("infer_pos", 0, 0, 0, 4, 1, 0, 0);
    wa = '{-3, -1, 2, 5};
    eval("infer_neg", 0, 0, 0, 4, 1, 0, 0);
    wa = '{3, -1, 2, 5};
    eval("train_dec", 0, 1, 0, 4, 1, 0, 0);
    xa = '{127, -128, 0, 0};
    wa = '{120, 127, 0, 0};
    eval("sat", 0, 1, 1, 4, 1, 0, 0);
    xa = '{8, 4, 0, 0};
    wa = '{-2, 1, 0, 0};
    eval("short_bp", 0, 1, 1, 2, 1, 3, 0);
    xa = '{10, 20, -5, 4};
    wa = '{-3, -1, 2, 5};
    eval("mid_start", 0, 1, 1, 4, 1, 0, 1);
    wa = '{3, -1, 2, 5};
    eval("no_last", 0, 0, 0, 4, 0, 0, 0);
    xa = '{-7, 9, 3, -100};
    wa = '{6, 2, -11, 1};
    eval("bias_train", -5, 1, 1, 3, 1, 1, 0);

    @(negedge clk);
    start = 1'b1;
    bias = 8'sd50;
    train = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_x = 8'sd9;
    in_w = 8'sd9;
    repeat (2) @(negedge clk);
    nRst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    chk("post_reset.busy", busy, 0);
    xa = '{10, 20, -5, 4};
    wa = '{-3, -1, 2, 5};
    eval("after_reset", 0, 1, 1, 4, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
